imem_loader: RTL

Boot-time writer for the instruction memory that the fetch stage reads. It receives a framed byte stream (length header, payload, checksum) over a valid/ready byte interface and assembles little-endian 32-bit words. It issues sequential single-word writes to the instruction-memory write port, then reports done or error. The system holds the core in reset until o_done, so stall_fetch is inactive during loading and the gated fetch clock runs freely.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader_byte_to_word_packer.sv | 46 ++++
 rtl/imem_loader.sv | 108 ++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    SUM,
    DONE,
    ERR
  } state_e;

  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_byte_to_word_packer.sv
// Packs accepted bytes little-endian into a 32-bit word and emits a one-cycle
// word-complete pulse the cycle after the last lane is filled.
module byte_to_word_packer
  import imem_loader_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  input  logic        emit_i,
  output logic [1:0]  lane_o,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  lane_q;
  logic [31:0] word_q;
  logic        word_valid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lane_q       <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
    end else begin
      word_valid_q <= byte_valid_i && emit_i && (lane_q == LAST_LANE);
      if (clear_i) begin
        lane_q <= '0;
        word_q <= '0;
      end else if (byte_valid_i) begin
        word_q[8*lane_q +: 8] <= byte_i;
        lane_q                <= lane_q + 2'd1;
      end
    end
  end

  // The completed word stays intact through the pulse cycle even if lane 0 of
  // the next word is accepted in that same cycle.
  assign lane_o       = lane_q;
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length/payload/checksum byte frame and writes the payload
// as sequential 32-bit words into the instruction memory.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int MAX_WORDS = 1024
) (
  input  logic              clock_stall_fetch,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  output logic              o_rx_ready,
  output logic              o_imem_wren,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error,
  output logic [ADDR_W:0]   o_word_count
);

  localparam logic [ADDR_W:0] CNT_ONE = (ADDR_W+1)'(1);

  state_e          state_q;
  logic [ADDR_W:0] word_count_q;
  logic [ADDR_W:0] len_q;
  logic [7:0]      csum_q;

  logic        rx_fire;
  logic        start_fire;
  logic        pack_valid;
  logic [1:0]  lane;
  logic [31:0] word;
  logic        word_valid;
  logic [31:0] len_full;

  assign o_rx_ready = (state_q == LEN) || (state_q == DATA) || (state_q == SUM);
  assign o_busy     = o_rx_ready;
  assign o_done     = (state_q == DONE);
  assign o_error    = (state_q == ERR);

  assign rx_fire    = i_rx_valid && o_rx_ready;
  assign start_fire = i_start && !o_busy;
  assign pack_valid = rx_fire && ((state_q == LEN) || (state_q == DATA));
  // Bytes 0..2 of the length already sit in the packer; the 4th is on the bus.
  assign len_full   = {i_rx_data, word[23:0]};

  byte_to_word_packer u_packer (
    .clk_i        (clock_stall_fetch),
    .rst_ni       (i_reset),
    .clear_i      (start_fire),
    .byte_valid_i (pack_valid),
    .byte_i       (i_rx_data),
    .emit_i       (state_q == DATA),
    .lane_o       (lane),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clock_stall_fetch or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      word_count_q <= '0;
      len_q        <= '0;
      csum_q       <= '0;
    end else begin
      if (word_valid) word_count_q <= word_count_q + CNT_ONE;
      case (state_q)
        IDLE, DONE, ERR: begin
          if (i_start) begin
            state_q      <= LEN;
            word_count_q <= '0;
            csum_q       <= '0;
          end
        end
        LEN: begin
          if (rx_fire && lane == 2'(BYTES_PER_WORD - 1)) begin
            len_q <= len_full[ADDR_W:0];
            if (len_full == 32'd0)                 state_q <= SUM;
            else if (len_full > 32'(MAX_WORDS))    state_q <= ERR;
            else                                   state_q <= DATA;
          end
        end
        DATA: begin
          // Checksum covers payload bytes only. Leave DATA on the last byte so a
          // checksum byte arriving during the final write cycle lands in SUM.
          if (rx_fire) begin
            csum_q <= csum_q + i_rx_data;
            if (lane == 2'(BYTES_PER_WORD - 1) && (word_count_q + CNT_ONE) == len_q)
              state_q <= SUM;
          end
        end
        SUM: begin
          if (rx_fire) state_q <= (i_rx_data == csum_q) ? DONE : ERR;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_imem_wren  = word_valid;
  assign o_imem_addr  = word_count_q[ADDR_W-1:0];
  assign o_imem_wdata = word;
  assign o_word_count = word_count_q;

endmodule
